// File: rtl/apb_to_ahb_bridge.sv
// APB4 responder issuing one non-pipelined AHB-Lite SINGLE per APB transfer.
// Optional APB2AHB_PSTRB_EN: write strobes select HSIZE and HADDR[1:0].
module apb_to_ahb_bridge #(
   parameter int unsigned PADDR_WIDTH = 16,
   parameter logic [31:0] HADDR_BASE  = 32'h2000_0000
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic                   PSEL,
   input  logic                   PENABLE,
   input  logic [PADDR_WIDTH-1:0] PADDR,
   input  logic                   PWRITE,
   input  logic [31:0]            PWDATA,
   input  logic [3:0]             PSTRB,
   input  logic [2:0]             PPROT,
   output logic                   PREADY,
   output logic [31:0]            PRDATA,
   output logic                   PSLVERR,
   output logic [31:0]            HADDR,
   output logic [1:0]             HTRANS,
   output logic [2:0]             HSIZE,
   output logic [2:0]             HBURST,
   output logic                   HWRITE,
   output logic [3:0]             HPROT,
   output logic                   HNONSEC,
   output logic                   HMASTLOCK,
   output logic [31:0]            HWDATA,
   input  logic [31:0]            HRDATA,
   input  logic                   HREADY,
   input  logic                   HRESP
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_RESP
   } state_t;

   state_t state_q, state_d;

   logic        setup;
   logic        dec_ok;
   logic [2:0]  dec_size;
   logic [1:0]  dec_lo;
   logic [31:0] addr_full;
   logic        load;
   logic        cap_rsp;
   logic        drop_q;

   logic [31:0] haddr_q;
   logic        hwrite_q;
   logic [2:0]  hsize_q;
   logic [3:0]  hprot_q;
   logic        hnonsec_q;
   logic [31:0] hwdata_q;
   logic [31:0] prdata_q;
   logic        pslverr_q;

   assign setup     = PSEL & ~PENABLE;
   assign addr_full = HADDR_BASE | 32'(PADDR);

`ifdef APB2AHB_PSTRB_EN
   always_comb begin
      dec_ok   = 1'b1;
      dec_size = 3'b010;
      dec_lo   = 2'b00;
      if (PWRITE) begin
         case (PSTRB)
            4'b0001: begin dec_size = 3'b000; dec_lo = 2'd0; end
            4'b0010: begin dec_size = 3'b000; dec_lo = 2'd1; end
            4'b0100: begin dec_size = 3'b000; dec_lo = 2'd2; end
            4'b1000: begin dec_size = 3'b000; dec_lo = 2'd3; end
            4'b0011: begin dec_size = 3'b001; dec_lo = 2'd0; end
            4'b1100: begin dec_size = 3'b001; dec_lo = 2'd2; end
            4'b1111: begin dec_size = 3'b010; dec_lo = 2'd0; end
            default: dec_ok = 1'b0;
         endcase
      end
   end
`else
   logic unused_strb;

   assign unused_strb = ^PSTRB;
   assign dec_ok      = 1'b1;
   assign dec_size    = 3'b010;
   assign dec_lo      = 2'b00;
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A dropped PSEL still lets the AHB side finish, but skips RESP
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      cap_rsp = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (setup) begin
               load    = 1'b1;
               state_d = dec_ok ? S_ADDR : S_RESP;
            end
         end
         S_ADDR: begin
            if (HREADY) state_d = S_DATA;
         end
         S_DATA: begin
            if (HREADY) begin
               if (drop_q || !PSEL) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_RESP;
                  cap_rsp = 1'b1;
               end
            end
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         haddr_q   <= '0;
         hwrite_q  <= 1'b0;
         hsize_q   <= 3'b010;
         hprot_q   <= 4'b0011;
         hnonsec_q <= 1'b1;
         hwdata_q  <= '0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         if (load) begin
            haddr_q   <= {addr_full[31:2], dec_lo};
            hwrite_q  <= PWRITE;
            hsize_q   <= dec_size;
            hprot_q   <= {2'b00, PPROT[0], ~PPROT[2]};
            hnonsec_q <= PPROT[1];
            hwdata_q  <= PWDATA;
            drop_q    <= 1'b0;
            if (!dec_ok) begin
               prdata_q  <= '0;
               pslverr_q <= 1'b1;
            end
         end
         if ((state_q == S_ADDR || state_q == S_DATA) && !PSEL) begin
            drop_q <= 1'b1;
         end
         if (cap_rsp) begin
            prdata_q  <= hwrite_q ? 32'h0 : HRDATA;
            pslverr_q <= HRESP;
         end
      end
   end

   assign HTRANS    = (state_q == S_ADDR) ? 2'b10 : 2'b00;
   assign HADDR     = haddr_q;
   assign HWRITE    = hwrite_q;
   assign HSIZE     = hsize_q;
   assign HPROT     = hprot_q;
   assign HNONSEC   = hnonsec_q;
   assign HWDATA    = hwdata_q;
   assign HBURST    = 3'b000;
   assign HMASTLOCK = 1'b0;

   assign PREADY  = (state_q == S_RESP);
   assign PRDATA  = prdata_q;
   assign PSLVERR = pslverr_q;

endmodule

// File: doc/apb_to_ahb_bridge.md
Name: apb_to_ahb_bridge

Overview:
- APB4 responder that converts each APB transfer into a single AHB-Lite transfer. It is the reverse direction of the system's AHB-to-APB bridge.
- It lets APB-side initiators (debug/config agents, test controllers) reach AHB memory and peripherals.
- One APB transfer maps to exactly one non-pipelined AHB SINGLE transfer.
- The APB side is stalled with PREADY low until the AHB data phase completes.

Parameters:
- PADDR_WIDTH, 16, width of the APB address port.
- HADDR_BASE, 32'h2000_0000, base ORed onto the zero-extended PADDR to form HADDR; bits below PADDR_WIDTH must be zero.

Ports:
- HCLK  in  1  clock shared by the APB and AHB sides
- HRESETn  in  1  reset, asynchronous, active-low
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PADDR  in  PADDR_WIDTH  APB address
- PWRITE  in  1  APB write
- PWDATA  in  32  APB write data
- PSTRB  in  4  APB byte strobes
- PPROT  in  3  APB protection
- PREADY  out  1  APB ready
- PRDATA  out  32  APB read data
- PSLVERR  out  1  APB error
- HADDR  out  32  AHB address
- HTRANS  out  2  AHB transfer type
- HSIZE  out  3  AHB size
- HBURST  out  3  AHB burst, constant 3'b000 (SINGLE)
- HWRITE  out  1  AHB write
- HPROT  out  4  AHB protection
- HNONSEC  out  1  AHB security attribute
- HMASTLOCK  out  1  constant 0
- HWDATA  out  32  AHB write data
- HRDATA  in  32  AHB read data
- HREADY  in  1  AHB transfer done
- HRESP  in  1  AHB error response

Behaviour:
- Clock and reset: single clock HCLK; HRESETn asynchronous, active-low.
- Reset values: state IDLE; HTRANS=2'b00; HADDR=0; HWRITE=0; HSIZE=3'b010; HPROT=4'b0011; HNONSEC=1; HWDATA=0; PREADY=0; PRDATA=0; PSLVERR=0.
- States:
  - IDLE: if PSEL=1 and PENABLE=0 (setup phase), capture PADDR, PWRITE, PWDATA, PSTRB, PPROT, then go to ADDR. If the size decode is illegal, go to RESP with the error flag set and issue no AHB transfer.
  - ADDR: HTRANS=NONSEQ (2'b10) with HADDR, HWRITE, HSIZE, HPROT, HNONSEC valid. Hold until HREADY=1, then go to DATA.
  - DATA: HTRANS=IDLE; HWDATA=captured data. Hold until HREADY=1, then capture HRDATA (reads only) and HRESP, and go to RESP.
  - RESP: PREADY=1 for exactly one cycle; PRDATA=captured read data (0 on writes); PSLVERR=captured HRESP. Return to IDLE.
- PREADY is 0 in every state except RESP.
- PRDATA and PSLVERR hold their values after RESP until the next RESP.
- Latency: with a zero-wait AHB slave, the APB transfer takes setup + 3 access cycles. Each AHB wait state adds one cycle.
- Address: HADDR = HADDR_BASE | zero-extended PADDR. HADDR[1:0] per the size rule below.
- Protection mapping:
  - HPROT[0] = ~PPROT[2]
  - HPROT[1] = PPROT[0]
  - HPROT[3:2] = 2'b00
  - HNONSEC = PPROT[1]
- HRESP: the two-cycle error response is sampled only on the HREADY=1 cycle. No following transfer exists, so no cancel is needed.
- PSEL deasserted mid-transfer (APB protocol violation): the AHB transfer still completes. The result is discarded and the block returns to IDLE without asserting PREADY.
- Reset asserted mid-operation: immediate return to IDLE with reset values on all outputs. An in-flight AHB transfer is abandoned.

Optional Feature:
- Macro: APB2AHB_PSTRB_EN.
- With the macro, writes decode PSTRB into size and address:
  - 0001/0010/0100/1000: byte, HADDR[1:0]=0/1/2/3.
  - 0011/1100: halfword, HADDR[1:0]=0/2.
  - 1111: word, HADDR[1:0]=0.
  - Any other write pattern, including 0000: PSLVERR=1 with no AHB transfer; PREADY asserts in the first access cycle.
  - Reads are always word size, with HADDR[1:0]=0 and PSTRB ignored.
- Without the macro, PSTRB is ignored: HSIZE is always word and HADDR[1:0]=0.

Test Plan:
- Word write, PADDR=16'h0104, PWDATA=32'hA5A5_1234, HREADY=1 -> one NONSEQ with HADDR=32'h2000_0104, HWRITE=1, HSIZE=3'b010; HWDATA=32'hA5A5_1234 in the following cycle; PREADY=1 in the 3rd access cycle; PSLVERR=0.
- Read PADDR=16'h0010, slave returns HRDATA=32'hDEAD_BEEF after 2 wait states in the data phase -> PRDATA=32'hDEAD_BEEF; PREADY high in access cycle 5; exactly one NONSEQ issued.
- Write while the slave holds HREADY=0 for 3 cycles in the address phase -> HADDR/HTRANS stable throughout; PREADY=0 until the transfer completes.
- Read where the slave returns a two-cycle HRESP=1 -> PSLVERR=1 with PREADY=1; next transfer has PSLVERR=0.
- With APB2AHB_PSTRB_EN: write PSTRB=4'b0100 -> HSIZE=3'b000, HADDR[1:0]=2'b10. PSTRB=4'b0110 -> HTRANS stays IDLE; PSLVERR=1 and PREADY=1 in the first access cycle.
- HRESETn pulsed low during the ADDR state -> HTRANS=IDLE and PREADY=0 immediately; the next APB transfer completes normally.
